spi_slave: RTL and testbench

SPI responder (mode 0, CPOL=0/CPHA=0, MSB first, 8-bit frames) for the SoC side of a link to an external SPI master. Oversamples the external sclk/cs_n/mosi pins in the system clock domain and exposes a byte-wide transmit holding register and a received-byte strobe to the rest of the SoC. It is the counterpart of our SPI initiator block and talks to it byte-for-byte.

---
 rtl/spi_slave_if.sv | 25 ++
 rtl/spi_slave.sv | 158 +++++++++++++++
 tb/tb_spi_slave.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - pin and SoC-side signal bundle for spi_slave
interface spi_slave_if;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       tx_underrun;

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun
    );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 responder, 8-bit MSB-first, pins oversampled in clk domain
module spi_slave #(
    parameter logic [7:0] IDLE_FILL = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_slave_if.slave  bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state, state_next;
    logic [2:0] sclk_sync;
    logic [2:0] cs_sync;
    logic [1:0] mosi_sync;
    logic [1:0] settle;
    logic       armed;

    logic [7:0] hold;
    logic       hold_full;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [7:0] rx_data_r;
    logic [2:0] bit_cnt;
    logic       miso_r;
    logic       miso_oe_r;
    logic       rx_valid_r;
    logic       underrun_r;

    logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic       start, stop, rx_step, tx_step, load;
    logic [7:0] load_byte;

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign load_byte = hold_full ? hold : IDLE_FILL;

    // Sync stages reset to the deselected level; a frame may start only once
    // cs_n has been seen high with real pin data, so reset mid-frame needs a fresh fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= 3'b000;
            cs_sync   <= 3'b111;
            mosi_sync <= 2'b00;
            settle    <= 2'd0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], bus.sclk};
            cs_sync   <= {cs_sync[1:0], bus.cs_n};
            mosi_sync <= {mosi_sync[0], bus.mosi};
            if (settle != 2'd3)
                settle <= settle + 2'd1;
            armed <= armed | ((settle == 2'd3) & cs_sync[2]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        rx_step    = 1'b0;
        tx_step    = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall && armed) begin
                    state_next = ACTIVE;
                    start      = 1'b1;
                    load       = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    stop       = 1'b1;
                end else begin
                    rx_step = sclk_rise;
                    if (sclk_fall) begin
                        if (bit_cnt == 3'd0)
                            load = 1'b1;
                        else
                            tx_step = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold       <= 8'h00;
            hold_full  <= 1'b0;
            tx_shift   <= IDLE_FILL;
            rx_shift   <= 8'h00;
            rx_data_r  <= 8'h00;
            bit_cnt    <= 3'd0;
            miso_r     <= 1'b1;
            miso_oe_r  <= 1'b0;
            rx_valid_r <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            underrun_r <= 1'b0;

            if (load) begin
                tx_shift   <= load_byte;
                miso_r     <= load_byte[7];
                underrun_r <= ~hold_full;
            end
            if (tx_step) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
                miso_r   <= tx_shift[6];
            end
            if (start) begin
                miso_oe_r <= 1'b1;
                bit_cnt   <= 3'd0;
            end
            if (stop) begin
                miso_oe_r <= 1'b0;
                miso_r    <= 1'b1;
                bit_cnt   <= 3'd0;
            end
            if (rx_step) begin
                rx_shift <= {rx_shift[6:0], mosi_sync[1]};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data_r  <= {rx_shift[6:0], mosi_sync[1]};
                    rx_valid_r <= 1'b1;
                end
            end

            // A load from an empty register takes the fill byte, so a same-cycle write still lands.
            if (load && hold_full) begin
                hold_full <= 1'b0;
            end else if (bus.tx_valid && !hold_full) begin
                hold      <= bus.tx_data;
                hold_full <= 1'b1;
            end
        end
    end

    assign bus.miso        = miso_r;
    assign bus.miso_oe     = miso_oe_r;
    assign bus.tx_ready    = ~hold_full;
    assign bus.rx_data     = rx_data_r;
    assign bus.rx_valid    = rx_valid_r;
    assign bus.busy        = ~cs_sync[1];
    assign bus.tx_underrun = underrun_r;
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   rv_cnt = 0;
    int   un_cnt = 0;
    int   rv0, uc0;
    logic [7:0] r1, r2;

    spi_slave_if bus ();

    spi_slave dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1)
            rv_cnt++;
        if (bus.tx_underrun === 1'b1)
            un_cnt++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_tx(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Master side, sclk = clk/8; returns right after the last sclk fall.
    task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            bus.mosi = b[i];
            repeat (4) @(negedge clk);
            bus.sclk = 1'b1;
            r[i] = bus.miso;
            repeat (4) @(negedge clk);
            bus.sclk = 1'b0;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.sclk     = 1'b0;
        bus.cs_n     = 1'b1;
        bus.mosi     = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        chk("rst_miso",     {7'd0, bus.miso},        8'h01);
        chk("rst_miso_oe",  {7'd0, bus.miso_oe},     8'h00);
        chk("rst_tx_ready", {7'd0, bus.tx_ready},    8'h01);
        chk("rst_rx_data",  bus.rx_data,             8'h00);
        chk("rst_rx_valid", {7'd0, bus.rx_valid},    8'h00);
        chk("rst_busy",     {7'd0, bus.busy},        8'h00);
        chk("rst_underrun", {7'd0, bus.tx_underrun}, 8'h00);

        // Single byte
        write_tx(8'hA5);
        chk("single_hold_full", {7'd0, bus.tx_ready}, 8'h00);
        cs_low();
        chk("single_busy",      {7'd0, bus.busy},     8'h01);
        chk("single_oe",        {7'd0, bus.miso_oe},  8'h01);
        chk("single_ready_ret", {7'd0, bus.tx_ready}, 8'h01);
        chk("single_first_bit", {7'd0, bus.miso},     8'h01);
        chk("single_underrun",  un_cnt[7:0],          8'h00);
        xfer(8'h3C, 8, r1);
        chk("single_miso_byte", r1,                   8'hA5);
        chk("single_rx_data",   bus.rx_data,          8'h3C);
        chk("single_rv_cnt",    rv_cnt[7:0],          8'h01);
        cs_high();
        chk("single_oe_off",    {7'd0, bus.miso_oe},  8'h00);
        chk("single_miso_idle", {7'd0, bus.miso},     8'h01);
        chk("single_busy_off",  {7'd0, bus.busy},     8'h00);
        chk("single_rv_once",   rv_cnt[7:0],          8'h01);

        // Underrun: start load and byte-boundary load both substitute the fill byte
        uc0 = un_cnt;
        cs_low();
        xfer(8'h81, 8, r1);
        xfer(8'h7E, 8, r2);
        chk("under_byte0",   r1,                    8'hFF);
        chk("under_byte1",   r2,                    8'hFF);
        chk("under_pulses",  8'(un_cnt - uc0),      8'h02);
        chk("under_rx_data", bus.rx_data,           8'h7E);
        cs_high();
        // the sclk fall closing byte two is another boundary reload from empty
        chk("under_trailing", 8'(un_cnt - uc0),     8'h03);

        // Streaming
        write_tx(8'h01);
        rv0 = rv_cnt;
        cs_low();
        chk("stream_ready", {7'd0, bus.tx_ready}, 8'h01);
        write_tx(8'h02);
        xfer(8'h10, 8, r1);
        chk("stream_rx0",   bus.rx_data,          8'h10);
        xfer(8'h20, 8, r2);
        chk("stream_tx0",   r1,                   8'h01);
        chk("stream_tx1",   r2,                   8'h02);
        chk("stream_rx1",   bus.rx_data,          8'h20);
        chk("stream_rv",    8'(rv_cnt - rv0),     8'h02);
        cs_high();

        // Abort after 5 bits, then a clean frame
        write_tx(8'hC3);
        rv0 = rv_cnt;
        cs_low();
        xfer(8'hFF, 5, r1);
        chk("abort_bits",    {r1[7:3], 3'b000},    8'hC0);
        cs_high();
        chk("abort_oe",      {7'd0, bus.miso_oe},  8'h00);
        chk("abort_no_rv",   8'(rv_cnt - rv0),     8'h00);
        chk("abort_rx_keep", bus.rx_data,          8'h20);
        write_tx(8'h5A);
        cs_low();
        xfer(8'h96, 8, r1);
        chk("abort_next_tx", r1,                   8'h5A);
        chk("abort_next_rx", bus.rx_data,          8'h96);
        chk("abort_next_rv", 8'(rv_cnt - rv0),     8'h01);
        cs_high();

        // Write lands in the same cycle as the cs_n-fall load from empty
        uc0 = un_cnt;
        @(negedge clk);
        bus.cs_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.tx_data  = 8'h77;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("simul_underrun", 8'(un_cnt - uc0),     8'h01);
        chk("simul_held",     {7'd0, bus.tx_ready}, 8'h00);
        xfer(8'h5C, 8, r1);
        xfer(8'h66, 8, r2);
        chk("simul_byte0",    r1,                   8'hFF);
        chk("simul_byte1",    r2,                   8'h77);
        chk("simul_rx",       bus.rx_data,          8'h66);
        cs_high();

        // Asynchronous reset after 3 bits
        cs_low();
        write_tx(8'hE7);
        xfer(8'hFF, 3, r1);
        chk("rstmid_pre_oe",    {7'd0, bus.miso_oe},  8'h01);
        chk("rstmid_pre_ready", {7'd0, bus.tx_ready}, 8'h00);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstmid_miso",     {7'd0, bus.miso},        8'h01);
        chk("rstmid_oe",       {7'd0, bus.miso_oe},     8'h00);
        chk("rstmid_ready",    {7'd0, bus.tx_ready},    8'h01);
        chk("rstmid_rx_data",  bus.rx_data,             8'h00);
        chk("rstmid_rx_valid", {7'd0, bus.rx_valid},    8'h00);
        chk("rstmid_busy",     {7'd0, bus.busy},        8'h00);
        chk("rstmid_underrun", {7'd0, bus.tx_underrun}, 8'h00);
        bus.cs_n = 1'b1;
        bus.sclk = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        write_tx(8'h4B);
        cs_low();
        xfer(8'hD2, 8, r1);
        chk("post_rst_tx", r1,          8'h4B);
        chk("post_rst_rx", bus.rx_data, 8'hD2);
        cs_high();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
